draw_control: RTL

Sequencer that sits directly upstream of the VGA item drawer. It accepts one "move item" request at a time (press or garbage, target slot), erases the item's previously drawn slot by driving the drawer with `erase=1` for exactly one item's pixel count, then draws it at the new slot. It remembers the last drawn slot per item type, restarts the drawer's pixel counters before each phase, and gates the VGA write enable so only complete, aligned rectangles reach the frame buffer.

---
 rtl/draw_control.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/draw_control.sv
// draw_control: sequences one "move item" request for the VGA item drawer.
// Erases the item's previously drawn slot (if any), then draws it at the
// requested slot. It pulses the drawer's counter reset before each phase
// and raises plot_en only while a phase is emitting pixels.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req, req_item, req_pos request strobe, item (1=press, 0=garbage), slot
//   busy, done            transaction in flight / one-cycle completion pulse
//   item, erase, position registered drawer controls
//   draw_rst_n            drawer reset, low for one cycle before each phase
//   plot_en               VGA write enable
module draw_control #(
  parameter int PRESS_PIXELS   = 2400,
  parameter int GARBAGE_PIXELS = 400,
  parameter int CNT_W          = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       req_item,
  input  logic [2:0] req_pos,
  output logic       busy,
  output logic       done,
  output logic       item,
  output logic       erase,
  output logic [2:0] position,
  output logic       draw_rst_n,
  output logic       plot_en
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC_E = 3'd1;
  localparam logic [2:0] S_ERASE  = 3'd2;
  localparam logic [2:0] S_SYNC_D = 3'd3;
  localparam logic [2:0] S_DRAW   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_PIXELS - 1);
  localparam logic [CNT_W-1:0] GARB_LAST  = CNT_W'(GARBAGE_PIXELS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cur_item_q, cur_item_d;
  logic [2:0]       cur_pos_q, cur_pos_d;
  logic [2:0]       prev_press_pos_q, prev_press_pos_d;
  logic             prev_press_vld_q, prev_press_vld_d;
  logic [2:0]       prev_garb_pos_q, prev_garb_pos_d;
  logic             prev_garb_vld_q, prev_garb_vld_d;
  logic             item_q, item_d;
  logic             erase_q, erase_d;
  logic [2:0]       pos_q, pos_d;

  logic accept, phase_last;

  // Out-of-range slots are dropped without any visible effect.
  assign accept     = req && (req_item ? (req_pos <= 3'd5) : (req_pos <= 3'd3));
  assign phase_last = (cnt_q == (cur_item_q ? PRESS_LAST : GARB_LAST));

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cur_item_d       = cur_item_q;
    cur_pos_d        = cur_pos_q;
    prev_press_pos_d = prev_press_pos_q;
    prev_press_vld_d = prev_press_vld_q;
    prev_garb_pos_d  = prev_garb_pos_q;
    prev_garb_vld_d  = prev_garb_vld_q;
    item_d           = item_q;
    erase_d          = erase_q;
    pos_d            = pos_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cur_item_d = req_item;
          cur_pos_d  = req_pos;
          item_d     = req_item;
          // Drawer controls are loaded here so they are already stable
          // during the sync cycle that restarts the drawer's counters.
          if (req_item ? prev_press_vld_q : prev_garb_vld_q) begin
            state_d = S_SYNC_E;
            pos_d   = req_item ? prev_press_pos_q : prev_garb_pos_q;
            erase_d = 1'b1;
          end else begin
            state_d = S_SYNC_D;
            pos_d   = req_pos;
            erase_d = 1'b0;
          end
        end
      end
      S_SYNC_E: begin
        cnt_d   = '0;
        state_d = S_ERASE;
      end
      S_ERASE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (phase_last) begin
          state_d = S_SYNC_D;
          pos_d   = cur_pos_q;
          erase_d = 1'b0;
        end
      end
      S_SYNC_D: begin
        cnt_d   = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (phase_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (cur_item_q) begin
          prev_press_pos_d = cur_pos_q;
          prev_press_vld_d = 1'b1;
        end else begin
          prev_garb_pos_d = cur_pos_q;
          prev_garb_vld_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      cur_item_q       <= 1'b0;
      cur_pos_q        <= 3'd0;
      prev_press_pos_q <= 3'd0;
      prev_press_vld_q <= 1'b0;
      prev_garb_pos_q  <= 3'd0;
      prev_garb_vld_q  <= 1'b0;
      item_q           <= 1'b0;
      erase_q          <= 1'b0;
      pos_q            <= 3'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cur_item_q       <= cur_item_d;
      cur_pos_q        <= cur_pos_d;
      prev_press_pos_q <= prev_press_pos_d;
      prev_press_vld_q <= prev_press_vld_d;
      prev_garb_pos_q  <= prev_garb_pos_d;
      prev_garb_vld_q  <= prev_garb_vld_d;
      item_q           <= item_d;
      erase_q          <= erase_d;
      pos_q            <= pos_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign draw_rst_n = !((state_q == S_SYNC_E) || (state_q == S_SYNC_D));
  assign plot_en    = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign item       = item_q;
  assign erase      = erase_q;
  assign position   = pos_q;

endmodule
